// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues one-outstanding word requests,
// and feeds the IF/ID register through a one-entry skid buffer.
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_BLOCK = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] fetch_pc_r;
    logic [31:0] pend_pc_r;
    logic        skid_valid_r;
    logic [31:0] skid_pc_r;
    logic [31:0] skid_instr_r;
    logic        drop_r;

    logic        consume_s;
    logic        resp_s;
    logic        grant_s;
    logic        outstanding_s;
    logic        skid_valid_next_s;

    // Handshake qualifiers and the skid occupancy at the end of this cycle
    always_comb begin
        consume_s     = id_valid & ~stall;
        resp_s        = imem_rvalid & ~drop_r & (state_r == S_WAIT);
        grant_s       = (state_r == S_REQ) & imem_gnt;
        outstanding_s = (((state_r == S_WAIT) | (state_r == S_DRAIN)) & ~imem_rvalid) | grant_s;
        if (consume_s & skid_valid_r) begin
            skid_valid_next_s = resp_s;
        end else if (~consume_s & id_valid & resp_s) begin
            skid_valid_next_s = 1'b1;
        end else begin
            skid_valid_next_s = skid_valid_r;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_REQ;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; redirect overrides the normal sequencing
    always_comb begin
        state_next_s = state_r;
        if (redirect) begin
            state_next_s = outstanding_s ? S_DRAIN : S_REQ;
        end else begin
            case (state_r)
                S_REQ:   state_next_s = imem_gnt ? S_WAIT : S_REQ;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_next_s = skid_valid_next_s ? S_BLOCK : S_REQ;
                    end else begin
                        state_next_s = S_WAIT;
                    end
                end
                S_BLOCK: state_next_s = skid_valid_next_s ? S_BLOCK : S_REQ;
                S_DRAIN: state_next_s = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_next_s = S_REQ;
            endcase
        end
    end

    // Outputs decoded from state and the IF/ID register
    always_comb begin
        imem_req  = (state_r == S_REQ) & ~reset;
        imem_addr = fetch_pc_r;
        if (id_valid) begin
            id_opcode = id_instr[6:0];
        end else begin
            id_opcode = 7'd0;
        end
    end

    // PC, drop flag, IF/ID and skid datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r   <= RESET_PC & 32'hFFFF_FFFC;
            pend_pc_r    <= 32'd0;
            drop_r       <= 1'b0;
            id_valid     <= 1'b0;
            id_pc        <= 32'd0;
            id_instr     <= 32'd0;
            skid_valid_r <= 1'b0;
            skid_pc_r    <= 32'd0;
            skid_instr_r <= 32'd0;
        end else if (redirect) begin
            fetch_pc_r   <= redirect_pc & 32'hFFFF_FFFC;
            drop_r       <= outstanding_s;
            id_valid     <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            if (grant_s) begin
                pend_pc_r  <= fetch_pc_r;
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if ((state_r == S_DRAIN) && imem_rvalid) begin
                drop_r <= 1'b0;
            end
            // The skid always drains first so a same-cycle response queues behind it
            if (consume_s) begin
                if (skid_valid_r) begin
                    id_valid     <= 1'b1;
                    id_pc        <= skid_pc_r;
                    id_instr     <= skid_instr_r;
                    skid_valid_r <= resp_s;
                    if (resp_s) begin
                        skid_pc_r    <= pend_pc_r;
                        skid_instr_r <= imem_rdata;
                    end
                end else if (resp_s) begin
                    id_valid <= 1'b1;
                    id_pc    <= pend_pc_r;
                    id_instr <= imem_rdata;
                end else begin
                    id_valid <= 1'b0;
                end
            end else if (resp_s) begin
                if (id_valid) begin
                    skid_valid_r <= 1'b1;
                    skid_pc_r    <= pend_pc_r;
                    skid_instr_r <= imem_rdata;
                end else begin
                    id_valid <= 1'b1;
                    id_pc    <= pend_pc_r;
                    id_instr <= imem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected grants and IF/ID deliveries are
// queued by the stimulus and popped by independent negedge monitors.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt = 1'b1;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0000_0013;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_stall = 1'b0;
    logic        w_id_valid;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_instr;
    logic [6:0]  w_id_opcode;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int k_lat = 1;
    int due = 0;
    logic        pending = 1'b0;
    logic [31:0] resp_addr = 32'h0;
    logic        w_flag = 1'b0;
    logic [31:0] req_q[$];
    logic [63:0] id_q[$];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode)
    );

    // Low address bits deliberately set: they must be ignored
    fetch_stage #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc), .stall(w_stall),
        .id_valid(w_id_valid), .id_pc(w_id_pc), .id_instr(w_id_instr), .id_opcode(w_id_opcode)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0] | 16'h0003};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_id(input logic [31:0] pc);
        id_q.push_back({pc, mem_word(pc)});
    endtask

    // Advance one cycle and drive the memory response due in the new cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pending && (due == cyc)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(resp_addr);
            pending     = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        w_rvalid = w_flag;
        w_flag   = 1'b0;
    endtask

    // Memory model: record grants and schedule their responses k_lat cycles later
    initial forever begin
        @(negedge clk);
        if (reset) begin
            pending = 1'b0;
            w_flag  = 1'b0;
        end else begin
            if (imem_req && imem_gnt) begin
                pending   = 1'b1;
                due       = cyc + k_lat;
                resp_addr = imem_addr;
            end
            w_flag = w_req && w_gnt;
        end
    end

    // Request monitor
    initial forever begin
        @(negedge clk);
        if (imem_req && imem_gnt) begin
            if (req_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL req_unexpected: got grant at %h expected none", imem_addr);
            end else begin
                check("req_addr", imem_addr, req_q.pop_front());
            end
        end
    end

    // IF/ID monitor: compares whenever decode consumes an instruction
    initial forever begin
        @(negedge clk);
        if (id_valid && !stall) begin
            if (id_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL id_unexpected: got pc %h instr %h expected none", id_pc, id_instr);
            end else begin
                logic [63:0] e;
                e = id_q.pop_front();
                check("id_pc", id_pc, e[63:32]);
                check("id_instr", id_instr, e[31:0]);
                check("id_opcode", 32'(id_opcode), 32'(e[6:0]));
            end
        end
    end

    initial begin
        // Reset state
        step(); step();
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_opcode", 32'(id_opcode), 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_wrap_req", 32'(w_req), 32'h0);

        // Stream from RESET_PC, k=1
        step(); reset = 1'b0; imem_gnt = 1'b1;
        req_q.push_back(32'h0000_0100); req_q.push_back(32'h0000_0104); req_q.push_back(32'h0000_0108);
        id_q.push_back({32'h0000_0100, 32'hA4A5_0103});
        id_q.push_back({32'h0000_0104, 32'hA4A1_0107});
        id_q.push_back({32'h0000_0108, 32'hA4AD_010B});
        @(negedge clk);
        check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        step(); step();
        @(negedge clk);
        check("wrap_second_req", 32'(w_req), 32'h1);
        check("wrap_second_addr", w_addr, 32'h0000_0000);
        step(); step();
        step(); imem_gnt = 1'b0;
        step(); step(); step();
        @(negedge clk);
        check("hold_req", 32'(imem_req), 32'h1);
        check("hold_addr", imem_addr, 32'h0000_010C);

        // Stall: first response held in IF/ID, second into skid
        step(); stall = 1'b1; imem_gnt = 1'b1;
        req_q.push_back(32'h0000_010C); req_q.push_back(32'h0000_0110);
        step(); step(); step();
        @(negedge clk);
        check("stall_id_pc", id_pc, 32'h0000_010C);
        step();
        @(negedge clk);
        check("block_req", 32'(imem_req), 32'h0);
        check("block_id_pc", id_pc, 32'h0000_010C);
        step();
        @(negedge clk);
        check("block_req2", 32'(imem_req), 32'h0);
        step(); stall = 1'b0;
        push_id(32'h0000_010C); push_id(32'h0000_0110);
        req_q.push_back(32'h0000_0114); push_id(32'h0000_0114);
        step();
        @(negedge clk);
        check("skid_out_valid", 32'(id_valid), 32'h1);
        check("skid_out_pc", id_pc, 32'h0000_0110);
        check("resume_req", 32'(imem_req), 32'h1);
        step(); imem_gnt = 1'b0;
        step(); step();

        // Redirect while waiting, k=3
        step(); imem_gnt = 1'b1; k_lat = 3; req_q.push_back(32'h0000_0118);
        step(); redirect = 1'b1; redirect_pc = 32'h0000_0203;
        step(); redirect = 1'b0; k_lat = 1;
        req_q.push_back(32'h0000_0200); push_id(32'h0000_0200);
        @(negedge clk);
        check("drain_req", 32'(imem_req), 32'h0);
        check("drain_id_valid", 32'(id_valid), 32'h0);
        step();
        step();
        @(negedge clk);
        check("stale_dropped", 32'(id_valid), 32'h0);
        check("redir_addr", imem_addr, 32'h0000_0200);
        step(); imem_gnt = 1'b0;
        step(); step();

        // Redirect in the grant cycle
        step(); imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0300;
        req_q.push_back(32'h0000_0204);
        step(); redirect = 1'b0;
        req_q.push_back(32'h0000_0300); push_id(32'h0000_0300);
        @(negedge clk);
        check("gnt_redir_req", 32'(imem_req), 32'h0);
        step();
        @(negedge clk);
        check("gnt_redir_addr", imem_addr, 32'h0000_0300);
        check("gnt_redir_id_valid", 32'(id_valid), 32'h0);
        step(); imem_gnt = 1'b0;
        step(); step();

        // PC wrap after redirect to the top word
        step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
        step(); redirect = 1'b0; imem_gnt = 1'b1;
        req_q.push_back(32'hFFFF_FFFC); req_q.push_back(32'h0000_0000);
        push_id(32'hFFFF_FFFC); push_id(32'h0000_0000);
        step(); step();
        step(); imem_gnt = 1'b0;
        step(); step();

        // Reset with IF/ID and skid both occupied
        step(); stall = 1'b1; imem_gnt = 1'b1;
        req_q.push_back(32'h0000_0004); req_q.push_back(32'h0000_0008);
        step(); step(); step();
        @(negedge clk);
        check("pre_rst_id_valid", 32'(id_valid), 32'h1);
        check("pre_rst_id_pc", id_pc, 32'h0000_0004);
        step(); reset = 1'b1;
        @(negedge clk);
        check("rst_now_req", 32'(imem_req), 32'h0);
        step();
        @(negedge clk);
        check("mid_rst_id_valid", 32'(id_valid), 32'h0);
        check("mid_rst_opcode", 32'(id_opcode), 32'h0);
        check("mid_rst_req", 32'(imem_req), 32'h0);
        step(); reset = 1'b0; stall = 1'b0;
        req_q.push_back(32'h0000_0100); push_id(32'h0000_0100);
        @(negedge clk);
        check("post_rst_req", 32'(imem_req), 32'h1);
        check("post_rst_addr", imem_addr, 32'h0000_0100);
        step(); imem_gnt = 1'b0;
        step(); step();

        for (int i = 0; i < 20 && (req_q.size() != 0 || id_q.size() != 0); i++) begin
            step();
        end
        total++;
        if (req_q.size() != 0 || id_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d reqs %0d instrs pending expected 0", req_q.size(), id_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
